// File: rtl/uart_tx_pkg.sv
// Shared UART transmitter definitions: frame geometry, idle line level and
// the serializer state encoding. The frame generator imports FRAME_WIDTH
// from here as well, so both ends always agree on the frame length.
package uart_tx_pkg;

    localparam int FRAME_WIDTH = 11;

    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2
    } TxState_e;

endpackage

// File: rtl/tx_frame_serializer.sv
// Parallel-in/serial-out stage of the UART transmitter. Captures one
// pre-assembled frame, then shifts it out LSB-first, one bit per baud tick.
// The line idles high, and a single-cycle Done pulse marks the end of the
// final bit period.
module tx_frame_serializer
    import uart_tx_pkg::IDLE_LEVEL;
    import uart_tx_pkg::TxState_e;
    import uart_tx_pkg::IDLE;
    import uart_tx_pkg::ARMED;
    import uart_tx_pkg::SHIFT;
#(
    parameter int FRAME_WIDTH = uart_tx_pkg::FRAME_WIDTH
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [FRAME_WIDTH-1:0] FrameIn,
    input  logic                   Send,
    input  logic                   BaudTick,
    output logic                   DataTx,
    output logic                   Busy,
    output logic                   Done
);

    localparam int CNT_WIDTH = $clog2(FRAME_WIDTH + 1);

    TxState_e               r_state;
    logic [FRAME_WIDTH-1:0] r_shiftReg;
    logic [CNT_WIDTH-1:0]   r_bitCount;
    logic                   r_dataTx;
    logic                   r_done;

    TxState_e               w_nextState;
    logic [FRAME_WIDTH-1:0] w_nextShiftReg;
    logic [CNT_WIDTH-1:0]   w_nextBitCount;
    logic                   w_nextDataTx;
    logic                   w_nextDone;

    // Next-state logic; every register holds unless a Send or BaudTick moves it.
    // A tick seen in the capture cycle is dropped so the start bit is a full period.
    // Shifting in 1s means a drained register can only ever present the idle level.
    always_comb begin
        w_nextState    = r_state;
        w_nextShiftReg = r_shiftReg;
        w_nextBitCount = r_bitCount;
        w_nextDataTx   = r_dataTx;
        w_nextDone     = 1'b0;
        case (r_state)
            IDLE: begin
                w_nextDataTx = IDLE_LEVEL;
                if (Send) begin
                    w_nextShiftReg = FrameIn;
                    w_nextBitCount = '0;
                    w_nextState    = ARMED;
                end
            end
            ARMED: begin
                if (BaudTick) begin
                    w_nextDataTx   = r_shiftReg[0];
                    w_nextShiftReg = {1'b1, r_shiftReg[FRAME_WIDTH-1:1]};
                    w_nextBitCount = CNT_WIDTH'(1);
                    w_nextState    = SHIFT;
                end
            end
            SHIFT: begin
                if (BaudTick) begin
                    if (r_bitCount == CNT_WIDTH'(FRAME_WIDTH)) begin
                        w_nextDataTx = IDLE_LEVEL;
                        w_nextDone   = 1'b1;
                        w_nextState  = IDLE;
                    end else begin
                        w_nextDataTx   = r_shiftReg[0];
                        w_nextShiftReg = {1'b1, r_shiftReg[FRAME_WIDTH-1:1]};
                        w_nextBitCount = r_bitCount + CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                w_nextDataTx = IDLE_LEVEL;
                w_nextState  = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame without a Done pulse.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_shiftReg <= '1;
            r_bitCount <= '0;
            r_dataTx   <= IDLE_LEVEL;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_shiftReg <= w_nextShiftReg;
            r_bitCount <= w_nextBitCount;
            r_dataTx   <= w_nextDataTx;
            r_done     <= w_nextDone;
        end
    end

    assign DataTx = r_dataTx;
    assign Busy   = (r_state != IDLE);
    assign Done   = r_done;

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Self-checking bench for tx_frame_serializer: a cycle-by-cycle vector table
// followed by directed multi-cycle sequences (slow baud, back-to-back frames,
// resets mid-frame).
module tb_tx_frame_serializer;
    import uart_tx_pkg::*;

    localparam int FW = FRAME_WIDTH;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct {
        logic          rst;
        logic          snd;
        logic          tck;
        logic [FW-1:0] frame;
        logic          expDataTx;
        logic          expBusy;
        logic          expDone;
    } Vec_t;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Send;
    logic          BaudTick;
    logic [FW-1:0] FrameIn;
    logic          DataTx;
    logic          Busy;
    logic          Done;

    int passCount  = 0;
    int checkCount = 0;

    Vec_t vecs[22];

    // Free-running 10 ns system clock.
    always #5 Clock = ~Clock;

    tx_frame_serializer #(.FRAME_WIDTH(FW)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .FrameIn  (FrameIn),
        .Send     (Send),
        .BaudTick (BaudTick),
        .DataTx   (DataTx),
        .Busy     (Busy),
        .Done     (Done)
    );

    task automatic checkOne(input string name, input logic act, input logic exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic checkOutput(input string name, input logic expD, input logic expB, input logic expDone);
        checkOne({name, " DataTx"}, DataTx, expD);
        checkOne({name, " Busy"}, Busy, expB);
        checkOne({name, " Done"}, Done, expDone);
    endtask

    // Drive one cycle of inputs; outputs are then sampled 1 ns after the edge.
    task automatic applyStimulus(input logic rst, input logic snd, input logic tck, input logic [FW-1:0] frame);
        Reset    = rst;
        Send     = snd;
        BaudTick = tck;
        FrameIn  = frame;
        @(posedge Clock);
        #1;
        Reset    = 1'b0;
        Send     = 1'b0;
        BaudTick = 1'b0;
    endtask

    // Send one frame with a tick every 'period' cycles, checking every cycle.
    // Returns right after the Done edge so a caller can chain the next Send.
    task automatic sendFrame(input logic [FW-1:0] frame, input int period, input logic withTick,
                             input logic midSend, input string tag);
        logic expD;
        int   doneSeen;
        expD     = 1'b1;
        doneSeen = 0;
        applyStimulus(1'b0, 1'b1, withTick, frame);
        checkOutput({tag, " capture"}, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k <= FW; k++) begin
            for (int q = 0; q < period - 1; q++) begin
                if (midSend && k == 4 && q == 0) applyStimulus(1'b0, 1'b1, 1'b0, '0);
                else applyStimulus(1'b0, 1'b0, 1'b0, ~frame);
                if (Done) doneSeen++;
                checkOutput($sformatf("%s hold before tick %0d", tag, k), expD, 1'b1, 1'b0);
            end
            applyStimulus(1'b0, 1'b0, 1'b1, ~frame);
            expD = (k < FW) ? frame[k] : 1'b1;
            if (Done) doneSeen++;
            checkOutput($sformatf("%s tick %0d", tag, k), expD, (k < FW), (k == FW));
        end
        checkOne({tag, " single Done"}, (doneSeen == 1), 1'b1);
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: vector table, then directed corner cases.
    initial begin
        vecs = '{
            '{H, L, L, 11'h000, H, L, L},  // reset
            '{L, L, L, 11'h000, H, L, L},  // idle
            '{L, H, L, 11'h5A6, H, H, L},  // capture
            '{L, L, L, 11'h000, H, H, L},  // armed, waiting
            '{L, L, H, 11'h000, L, H, L},  // bit0 start
            '{L, L, H, 11'h000, H, H, L},  // bit1
            '{L, L, L, 11'h000, H, H, L},  // no tick: hold
            '{L, H, H, 11'h000, H, H, L},  // bit2, Send ignored
            '{L, L, H, 11'h000, L, H, L},  // bit3
            '{L, L, H, 11'h000, L, H, L},  // bit4
            '{L, L, H, 11'h000, H, H, L},  // bit5
            '{L, L, H, 11'h000, L, H, L},  // bit6
            '{L, L, H, 11'h000, H, H, L},  // bit7
            '{L, L, H, 11'h000, H, H, L},  // bit8
            '{L, L, H, 11'h000, L, H, L},  // bit9
            '{L, L, H, 11'h000, H, H, L},  // bit10
            '{L, L, H, 11'h000, H, L, H},  // end of frame: Done
            '{L, L, L, 11'h000, H, L, L},  // idle again
            '{L, H, H, 11'h7FE, H, H, L},  // Send+tick from idle: no bit yet
            '{L, L, H, 11'h000, L, H, L},  // start bit
            '{H, L, H, 11'h000, H, L, L},  // reset beats tick
            '{L, L, H, 11'h000, H, L, L}   // tick in idle does nothing
        };

        Reset    = 1'b1;
        Send     = 1'b0;
        BaudTick = 1'b0;
        FrameIn  = '0;
        repeat (2) @(posedge Clock);
        #1;

        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].snd, vecs[i].tck, vecs[i].frame);
            checkOutput($sformatf("vec%0d", i), vecs[i].expDataTx, vecs[i].expBusy, vecs[i].expDone);
        end

        // 3-cycle reset mid-frame, with Send and tick asserted alongside it.
        applyStimulus(1'b0, 1'b1, 1'b0, 11'h74A);
        applyStimulus(1'b0, 1'b0, 1'b1, 11'h74A);
        applyStimulus(1'b0, 1'b0, 1'b1, 11'h74A);
        checkOutput("pre-reset bit1", 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 11'h000);
            checkOutput($sformatf("reset hold %0d", i), 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, (i % 2 == 0), 11'h000);
            checkOutput($sformatf("post-reset idle %0d", i), 1'b1, 1'b0, 1'b0);
        end

        // 8N1 frame at 16 cycles per bit.
        sendFrame(11'h74A, 16, 1'b0, 1'b0, "8N1");
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("8N1 after Done", 1'b1, 1'b0, 1'b0);

        // Send coincident with a tick from idle: start bit still a full period.
        sendFrame(11'h74A, 5, 1'b1, 1'b0, "send+tick");
        applyStimulus(1'b0, 1'b0, 1'b0, '0);

        // Second Send mid-frame with an all-zero frame is ignored.
        sendFrame(11'h2B4, 4, 1'b0, 1'b1, "busy-send");

        // Back-to-back: next Send lands in the Done cycle.
        sendFrame(11'h7FE, 3, 1'b0, 1'b0, "back-to-back");
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("b2b idle", 1'b1, 1'b0, 1'b0);

        // Reset after the 4th bit: immediate idle, no Done, then a fresh frame.
        applyStimulus(1'b0, 1'b1, 1'b0, 11'h74A);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 11'h000);
            applyStimulus(1'b0, 1'b0, 1'b1, 11'h000);
        end
        checkOutput("mid-frame bit3", 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 11'h000);
        checkOutput("mid-frame reset", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b0, 1'b0, (i % 2 == 1), 11'h000);
            checkOutput($sformatf("aborted frame quiet %0d", i), 1'b1, 1'b0, 1'b0);
        end
        sendFrame(11'h74A, 2, 1'b0, 1'b0, "fresh");
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("final idle", 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/tx_frame_serializer.md
# tx_frame_serializer

Parallel-in/serial-out stage of the UART transmitter, directly downstream of the frame generator. It captures one pre-built 11-bit frame and shifts it onto the TX line LSB-first, one bit per baud tick. It reports completion with a one-cycle done pulse and holds the line at idle (1) otherwise.

## Interface
- FRAME_WIDTH, 11, bits per frame: start, data, parity and stop/idle fill, exactly as assembled upstream.
- CNT_WIDTH, $clog2(FRAME_WIDTH+1), width of the bit counter; derived, not overridden.

- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- FrameIn  in  FRAME_WIDTH  frame to send; FrameIn[0] is the start bit and goes out first.
- Send  in  1  request; sampled only in IDLE.
- BaudTick  in  1  one-cycle strobe per bit period, from the baud generator.
- DataTx  out  1  serial TX line, registered.
- Busy  out  1  high while a frame is captured or in flight (state != IDLE).
- Done  out  1  one-cycle pulse when the final bit period ends, registered.

## Operation
- States:
  - IDLE: DataTx=1.
  - ARMED: frame captured, waiting for bit alignment.
  - SHIFT: bits on the line.
- IDLE + Send:
  - ShiftReg<=FrameIn, BitCount<=0, go to ARMED.
  - BaudTick in the same cycle is ignored, so the start bit is always a full period.
- ARMED + BaudTick:
  - DataTx<=ShiftReg[0].
  - ShiftReg<={1'b1, ShiftReg[FRAME_WIDTH-1:1]}.
  - BitCount<=1, go to SHIFT.
- SHIFT + BaudTick:
  - If BitCount==FRAME_WIDTH: DataTx<=1, Done<=1, go to IDLE.
  - Else: DataTx<=ShiftReg[0], shift in 1, BitCount<=BitCount+1.
- No BaudTick: all state held; DataTx stable.
- Send outside IDLE is ignored. FrameIn is not re-sampled once captured, so upstream may change it freely while Busy=1.
- Shift fill is 1, so a stale shift register can never emit 0.
- BitCount stays in 0..FRAME_WIDTH and never wraps.
- Reset (any state, including mid-frame):
  - Next edge: state=IDLE, DataTx=1, Busy=0, Done=0, ShiftReg=all 1s, BitCount=0.
  - No Done is generated for an aborted frame.
  - Reset has priority over Send and BaudTick in the same cycle.

## Timing
- Send accepted at edge N: Busy=1 from N+1.
- Start bit appears on DataTx the edge after the first BaudTick seen in ARMED, i.e. 1 cycle to 1 baud period plus 1 cycle after Send.
- Each bit is held for exactly one BaudTick interval.
- The frame occupies FRAME_WIDTH periods; the (FRAME_WIDTH+1)-th tick after ARMED returns the line to 1.
- Done and the return to IDLE happen on the same edge; Busy=0 in the Done cycle.
- Send asserted during the Done cycle is accepted, giving back-to-back frames with no extra idle bit beyond the frame's own stop/fill bits.
- Done is never high for more than one cycle. Done and Busy are never both high.

## Structure
- Shared package uart_tx_pkg:
  - state enum (IDLE, ARMED, SHIFT), 2 bits;
  - FRAME_WIDTH default constant;
  - IDLE_LEVEL=1'b1.
- The frame generator imports the same FRAME_WIDTH.
- Single module, no sub-module. Baud tick generation is a separate peer block, not instantiated here.

## Test plan
- **Reset.** Assert Reset for 3 cycles mid-operation, then release.
  - DataTx=1, Busy=0, Done=0 throughout; stays idle with no Send.
- **8N1 frame.** FrameIn=11'h74A (data 0xA5, 1 stop, idle fill), Send for 1 cycle, BaudTick every 16 cycles.
  - DataTx per period: 0,1,0,1,0,0,1,0,1,1,1, then idle.
  - Exactly one Done pulse, 1 cycle long, on the tick after the 11th bit.
- **Send + BaudTick in the same cycle from IDLE.**
  - No bit on that tick; start bit begins on the following tick, full length.
- **Send while Busy.** Second Send with FrameIn=11'h000 mid-frame.
  - Ignored; the original frame completes unchanged; exactly 1 Done.
- **Back-to-back.** Send during the Done cycle with FrameIn=11'h7FE.
  - Next start bit 0 appears on the next BaudTick after capture; no lost or duplicated bits.
- **Reset mid-frame.** Reset after the 4th bit.
  - DataTx=1 on the next edge, Busy=0, no Done.
  - A subsequent Send transmits a full fresh frame.
